voting_ballot_ctrl: RTL and testbench

//   Ballot session controller that sits between the booth buttons and the voting_machine counters.
//   - Presiding officer issues one ballot at a time.
//   - Accepts exactly one clean button press per ballot and rejects ambiguous presses.
//   - Forfeits the ballot on timeout.
//   - Emits a single-cycle one-hot vote strobe to the counter datapath.
//   - Locks the booth permanently once voting is over.

---
 rtl/voting_ballot_if.sv | 18 +
 rtl/voting_ballot_ctrl.sv | 151 +++++++++++++++
 tb/tb_voting_ballot_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/voting_ballot_if.sv
// Vote strobe bundle from the ballot controller to the counter datapath.
// master drives the strobe; slave is the counter side.
interface voting_ballot_if #(
  parameter int N_CAND = 3
);
  logic              o_vote_valid;
  logic [N_CAND-1:0] o_vote_sel;

  modport master (
    output o_vote_valid,
    output o_vote_sel
  );

  modport slave (
    input o_vote_valid,
    input o_vote_sel
  );
endinterface

// File: rtl/voting_ballot_ctrl.sv
// Ballot session controller: one clean press per issued ballot.
// `define BALLOT_SYNC_EN adds a 2-flop synchroniser on the buttons.
module voting_ballot_ctrl #(
  parameter int N_CAND      = 3,
  parameter int TIMEOUT_CYC = 100,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ballot_en,
  input  logic [N_CAND-1:0] i_candidate,
  input  logic              i_voting_over,
  voting_ballot_if.master   vote_if,
  output logic              o_ready,
  output logic              o_reject,
  output logic              o_timeout,
  output logic              o_closed,
  output logic [CNT_W-1:0]  o_ballots_cast
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_REL,
    S_CLOSED
  } state_t;

  state_t            state_q;
  logic [TW-1:0]     tmo_q;
  logic [N_CAND-1:0] prev_q;
  logic [N_CAND-1:0] btn;
  logic [N_CAND-1:0] rise;
  logic              vote_valid_q;
  logic [N_CAND-1:0] vote_sel_q;
  logic              ready_q;
  logic              reject_q;
  logic              timeout_q;
  logic              closed_q;
  logic [CNT_W-1:0]  cast_q;
  logic [CNT_W-1:0]  cast_d;
  logic              btn_multi;
  logic              rise_one;
  logic              vote_ok;
  logic              ambig;
  logic              tmo_hit;

`ifdef BALLOT_SYNC_EN
  logic [N_CAND-1:0] sync1_q;
  logic [N_CAND-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_candidate;
      sync2_q <= sync1_q;
    end
  end

  assign btn = sync2_q;
`else
  assign btn = i_candidate;
`endif

  // x & (x-1) clears the lowest set bit; nonzero means two or more set
  always_comb begin
    rise      = btn & ~prev_q;
    btn_multi = |(btn & (btn - 1'b1));
    rise_one  = (rise != '0) && !(|(rise & (rise - 1'b1)));
    vote_ok   = rise_one && (btn != '0) && !btn_multi;
    ambig     = (rise != '0) && btn_multi;
    tmo_hit   = (tmo_q == TMO_LAST);
    cast_d    = (cast_q == CNT_MAX) ? cast_q : cast_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      prev_q       <= '0;
      vote_valid_q <= 1'b0;
      vote_sel_q   <= '0;
      ready_q      <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      closed_q     <= 1'b0;
      cast_q       <= '0;
    end else begin
      prev_q       <= btn;
      vote_valid_q <= 1'b0;
      vote_sel_q   <= '0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      // closing the polls overrides anything qualifying this cycle
      if (i_voting_over) begin
        state_q  <= S_CLOSED;
        ready_q  <= 1'b0;
        closed_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (i_ballot_en) begin
              state_q <= S_ARMED;
              tmo_q   <= '0;
              ready_q <= 1'b1;
            end
          end
          S_ARMED: begin
            tmo_q <= tmo_q + 1'b1;
            if (vote_ok) begin
              vote_valid_q <= 1'b1;
              vote_sel_q   <= rise;
              cast_q       <= cast_d;
              state_q      <= S_WAIT_REL;
              ready_q      <= 1'b0;
            end else begin
              if (ambig)
                reject_q <= 1'b1;
              if (tmo_hit) begin
                timeout_q <= 1'b1;
                state_q   <= S_IDLE;
                ready_q   <= 1'b0;
              end
            end
          end
          S_WAIT_REL: begin
            if (btn == '0)
              state_q <= S_IDLE;
          end
          S_CLOSED: begin
            closed_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign vote_if.o_vote_valid = vote_valid_q;
  assign vote_if.o_vote_sel   = vote_sel_q;
  assign o_ready              = ready_q;
  assign o_reject             = reject_q;
  assign o_timeout            = timeout_q;
  assign o_closed             = closed_q;
  assign o_ballots_cast       = cast_q;

endmodule

// File: tb/tb_voting_ballot_ctrl.sv
// Directed bench for voting_ballot_ctrl (default build, 1-edge latency).
// A second instance with CNT_W=2 checks counter saturation.
module tb_voting_ballot_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ballot_en;
  logic [2:0] cand;
  logic       over;

  logic       ready, reject, tmo, closed;
  logic [5:0] cast;
  logic       ready2, reject2, tmo2, closed2;
  logic [1:0] cast2;

  int n_cmp = 0;
  int n_bad = 0;

  voting_ballot_if #(.N_CAND(3)) vif  ();
  voting_ballot_if #(.N_CAND(3)) vif2 ();

  voting_ballot_ctrl #(
    .N_CAND(3), .TIMEOUT_CYC(100), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ballot_en(ballot_en),
    .i_candidate(cand),
    .i_voting_over(over),
    .vote_if(vif.master),
    .o_ready(ready), .o_reject(reject),
    .o_timeout(tmo), .o_closed(closed),
    .o_ballots_cast(cast)
  );

  voting_ballot_ctrl #(
    .N_CAND(3), .TIMEOUT_CYC(100), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .i_ballot_en(ballot_en),
    .i_candidate(cand),
    .i_voting_over(over),
    .vote_if(vif2.master),
    .o_ready(ready2), .o_reject(reject2),
    .o_timeout(tmo2), .o_closed(closed2),
    .o_ballots_cast(cast2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] c;
    logic       ov;
    logic       v;
    logic [2:0] s;
    logic       rdy;
    logic       rej;
    logic       to;
    logic       cl;
    int         cast;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic en, logic [2:0] c, logic ov,
    logic v, logic [2:0] s, logic rdy,
    logic rej, logic to, logic cl, int cs
  );
    vec_t r;
    r.en = en; r.c = c; r.ov = ov;
    r.v = v; r.s = s; r.rdy = rdy;
    r.rej = rej; r.to = to; r.cl = cl;
    r.cast = cs;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string nm, logic v, logic [2:0] s,
                         logic rdy, logic rej, logic to,
                         logic cl, int cs);
    chk({nm, ".valid"},  32'(vif.o_vote_valid), 32'(v));
    chk({nm, ".sel"},    32'(vif.o_vote_sel), 32'(s));
    chk({nm, ".ready"},  32'(ready), 32'(rdy));
    chk({nm, ".reject"}, 32'(reject), 32'(rej));
    chk({nm, ".tmo"},    32'(tmo), 32'(to));
    chk({nm, ".closed"}, 32'(closed), 32'(cl));
    chk({nm, ".cast"},   32'(cast), 32'(cs));
    chk({nm, ".cast2"},  32'(cast2), 32'((cs > 3) ? 3 : cs));
  endtask

  initial begin
    int         c1, c2, c3, seen;
    logic [2:0] seq [8];
    seq = '{3'b001, 3'b010, 3'b001, 3'b100,
            3'b010, 3'b010, 3'b001, 3'b100};

    // vote, stray press, ambiguous, held button, WAIT_REL, close
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,0,0,0,0,0));
    tbl.push_back(mk(1,3'b000,0, 0,3'b000,1,0,0,0,0));
    tbl.push_back(mk(0,3'b001,0, 1,3'b001,0,0,0,0,1));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,0,0,0,0,1));
    tbl.push_back(mk(0,3'b001,0, 0,3'b000,0,0,0,0,1));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,0,0,0,0,1));
    tbl.push_back(mk(1,3'b000,0, 0,3'b000,1,0,0,0,1));
    tbl.push_back(mk(0,3'b011,0, 0,3'b000,1,1,0,0,1));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,1,0,0,0,1));
    tbl.push_back(mk(0,3'b010,0, 1,3'b010,0,0,0,0,2));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,0,0,0,0,2));
    tbl.push_back(mk(1,3'b100,0, 0,3'b000,1,0,0,0,2));
    tbl.push_back(mk(0,3'b100,0, 0,3'b000,1,0,0,0,2));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,1,0,0,0,2));
    tbl.push_back(mk(0,3'b100,0, 1,3'b100,0,0,0,0,3));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,0,0,0,0,3));
    tbl.push_back(mk(1,3'b000,0, 0,3'b000,1,0,0,0,3));
    tbl.push_back(mk(0,3'b001,0, 1,3'b001,0,0,0,0,4));
    tbl.push_back(mk(0,3'b011,0, 0,3'b000,0,0,0,0,4));
    tbl.push_back(mk(1,3'b000,0, 0,3'b000,0,0,0,0,4));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,0,0,0,0,4));
    tbl.push_back(mk(1,3'b010,0, 0,3'b000,1,0,0,0,4));
    tbl.push_back(mk(0,3'b011,0, 0,3'b000,1,1,0,0,4));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,1,0,0,0,4));
    tbl.push_back(mk(0,3'b100,0, 1,3'b100,0,0,0,0,5));
    tbl.push_back(mk(0,3'b000,0, 0,3'b000,0,0,0,0,5));
    tbl.push_back(mk(1,3'b000,0, 0,3'b000,1,0,0,0,5));
    tbl.push_back(mk(0,3'b001,1, 0,3'b000,0,0,0,1,5));
    tbl.push_back(mk(1,3'b000,0, 0,3'b000,0,0,0,1,5));
    tbl.push_back(mk(0,3'b010,0, 0,3'b000,0,0,0,1,5));

    rst = 1'b0; ballot_en = 1'b0; cand = '0; over = 1'b0;
    #2;
    chk_all("reset", 0, 3'b000, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;

    foreach (tbl[i]) begin
      ballot_en = tbl[i].en;
      cand      = tbl[i].c;
      over      = tbl[i].ov;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].v, tbl[i].s,
              tbl[i].rdy, tbl[i].rej, tbl[i].to,
              tbl[i].cl, tbl[i].cast);
    end
    ballot_en = 0; cand = '0; over = 0;

    // asynchronous reset mid-ARMED
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
    ballot_en = 1;
    step();
    chk("armed.ready", 32'(ready), 32'd1);
    ballot_en = 0;
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 3'b000, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    step();
    chk_all("post_rst", 0, 3'b000, 0, 0, 0, 0, 0);

    // eight ballots in sequence
    c1 = 0; c2 = 0; c3 = 0;
    for (int k = 0; k < 8; k++) begin
      ballot_en = 1; cand = '0;
      step();
      ballot_en = 0; cand = seq[k];
      step();
      chk($sformatf("seq%0d.valid", k), 32'(vif.o_vote_valid), 32'd1);
      chk($sformatf("seq%0d.sel", k), 32'(vif.o_vote_sel), 32'(seq[k]));
      chk($sformatf("seq%0d.cast2", k), 32'(cast2),
          32'((k + 1 > 3) ? 3 : k + 1));
      if (vif.o_vote_valid) begin
        if (vif.o_vote_sel == 3'b001) c1++;
        if (vif.o_vote_sel == 3'b010) c2++;
        if (vif.o_vote_sel == 3'b100) c3++;
      end
      cand = '0;
      step();
      chk($sformatf("seq%0d.strobe_off", k), 32'(vif.o_vote_valid), 32'd0);
    end
    chk("seq.c1", 32'(c1), 32'd3);
    chk("seq.c2", 32'(c2), 32'd3);
    chk("seq.c3", 32'(c3), 32'd2);
    chk("seq.cast", 32'(cast), 32'd8);
    chk("seq.cast2_sat", 32'(cast2), 32'd3);

    // timeout: 100 armed cycles, pulse on the 100th edge
    ballot_en = 1;
    step();
    ballot_en = 0;
    seen = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (tmo && seen == 0) seen = k;
    end
    chk("tmo.edge", 32'(seen), 32'd100);
    chk("tmo.ready", 32'(ready), 32'd0);
    cand = 3'b001;
    step();
    chk("tmo.late_press", 32'(vif.o_vote_valid), 32'd0);
    cand = '0;
    step();

    // vote on the timeout cycle wins
    ballot_en = 1;
    step();
    ballot_en = 0;
    for (int k = 1; k < 100; k++) step();
    chk("edge99.ready", 32'(ready), 32'd1);
    cand = 3'b010;
    step();
    chk("tmo_vote.valid", 32'(vif.o_vote_valid), 32'd1);
    chk("tmo_vote.sel", 32'(vif.o_vote_sel), 32'd2);
    chk("tmo_vote.tmo", 32'(tmo), 32'd0);
    chk("tmo_vote.cast", 32'(cast), 32'd9);
    cand = '0;
    step();
    step();
    chk("tmo_vote.no_pulse", 32'(tmo), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
